// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB RX packet control slice.
// Optional PID complement check is enabled by defining RX_PID_CHECK_EN.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    PID_WAIT,
    DATA_WAIT,
    DONE,
    ERR
  } rx_state_t;

  typedef logic [3:0] pid_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

  // Upper nibble of a USB PID byte must be the one's complement of the lower nibble.
  function automatic logic pid_check_ok(input logic [7:0] pid_byte);
    return pid_byte[7:4] == ~pid_byte[3:0];
  endfunction

endpackage

// File: rtl/rx_byte_cnt.sv
// Saturating payload byte counter with synchronous clear and at-max flag.
module rx_byte_cnt #(
  parameter int unsigned MAX_COUNT = 64,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !at_max_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MAX_VAL);

endmodule

// File: rtl/rx_packet_ctrl.sv
// USB bulk RX control FSM: SYNC check, PID latch, payload streaming into the RX FIFO.
// Define RX_PID_CHECK_EN to reject PID bytes whose check nibble is not the complement.
module rx_packet_ctrl
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 64,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_edge,
  input  logic             byte_rcvd,
  input  logic             bits_pending,
  input  logic             eop,
  input  logic [7:0]       rx_data,
  input  logic             fifo_full,
  output logic             cnt_clear,
  output logic             rcving,
  output logic             w_enable,
  output logic [3:0]       pid,
  output logic             pid_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_done,
  output logic             r_error
);

  rx_state_t state_q, state_d;
  logic      rcving_q, rcving_d;
  pid_t      pid_q, pid_d;
  logic      pid_valid_q, pid_valid_d;
  logic      pkt_done_q, pkt_done_d;
  logic      r_error_q, r_error_d;
  logic      eop_seen_q, eop_seen_d;
  logic      go_err, go_done;
  logic      pid_ok;
  logic      at_max;

`ifdef RX_PID_CHECK_EN
  assign pid_ok = pid_check_ok(rx_data);
`else
  assign pid_ok = 1'b1;
`endif

  assign cnt_clear = (state_q == IDLE) && start_edge;
  assign w_enable  = (state_q == DATA_WAIT) && byte_rcvd && !fifo_full && !at_max;

  rx_byte_cnt #(
    .MAX_COUNT(MAX_BYTES),
    .CNT_W    (CNT_W)
  ) u_byte_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (cnt_clear),
    .en_i    (w_enable),
    .count_o (byte_count),
    .at_max_o(at_max)
  );

  always_comb begin
    state_d     = state_q;
    rcving_d    = rcving_q;
    pid_d       = pid_q;
    pid_valid_d = pid_valid_q;
    pkt_done_d  = 1'b0;
    r_error_d   = r_error_q;
    eop_seen_d  = eop_seen_q;
    go_err      = 1'b0;
    go_done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d     = SYNC_WAIT;
          rcving_d    = 1'b1;
          r_error_d   = 1'b0;
          pid_valid_d = 1'b0;
        end
      end
      SYNC_WAIT: begin
        if (byte_rcvd) begin
          if (rx_data == SYNC_BYTE && !eop) state_d = PID_WAIT;
          else                              go_err  = 1'b1;
        end else if (eop) begin
          go_err = 1'b1;
        end
      end
      PID_WAIT: begin
        if (byte_rcvd) begin
          if (pid_ok && !eop) begin
            pid_d       = rx_data[3:0];
            pid_valid_d = 1'b1;
            state_d     = DATA_WAIT;
          end else begin
            go_err = 1'b1;
          end
        end else if (eop) begin
          go_err = 1'b1;
        end
      end
      DATA_WAIT: begin
        // A byte arriving with eop is resolved first; eop only finishes the packet if it was written.
        if (byte_rcvd) begin
          if (fifo_full || at_max) go_err  = 1'b1;
          else if (eop)            go_done = 1'b1;
        end else if (eop) begin
          if (bits_pending) go_err  = 1'b1;
          else              go_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        // Hold off until the SE0 has been seen and then released, so the tail of a bad packet is not re-parsed.
        if (eop) begin
          eop_seen_d = 1'b1;
        end else if (eop_seen_q) begin
          state_d    = IDLE;
          rcving_d   = 1'b0;
          eop_seen_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_err) begin
      state_d    = ERR;
      r_error_d  = 1'b1;
      eop_seen_d = eop;
    end
    if (go_done) begin
      state_d    = DONE;
      rcving_d   = 1'b0;
      pkt_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rcving_q    <= 1'b0;
      pid_q       <= '0;
      pid_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      r_error_q   <= 1'b0;
      eop_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcving_q    <= rcving_d;
      pid_q       <= pid_d;
      pid_valid_q <= pid_valid_d;
      pkt_done_q  <= pkt_done_d;
      r_error_q   <= r_error_d;
      eop_seen_q  <= eop_seen_d;
    end
  end

  assign rcving    = rcving_q;
  assign pid       = pid_q;
  assign pid_valid = pid_valid_q;
  assign pkt_done  = pkt_done_q;
  assign r_error   = r_error_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Self-checking bench for rx_packet_ctrl: packet table plus reset and same-cycle eop sequences.
module tb_rx_packet_ctrl;

  localparam int unsigned MAX_BYTES = 64;
  localparam int unsigned CNT_W     = 7;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start_edge = 1'b0;
  logic             byte_rcvd = 1'b0;
  logic             bits_pending = 1'b0;
  logic             eop = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             fifo_full = 1'b0;
  logic             cnt_clear;
  logic             rcving;
  logic             w_enable;
  logic [3:0]       pid;
  logic             pid_valid;
  logic [CNT_W-1:0] byte_count;
  logic             pkt_done;
  logic             r_error;

  always #5 clk = ~clk;

  rx_packet_ctrl #(
    .MAX_BYTES(MAX_BYTES),
    .SYNC_BYTE(8'h80)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start_edge  (start_edge),
    .byte_rcvd   (byte_rcvd),
    .bits_pending(bits_pending),
    .eop         (eop),
    .rx_data     (rx_data),
    .fifo_full   (fifo_full),
    .cnt_clear   (cnt_clear),
    .rcving      (rcving),
    .w_enable    (w_enable),
    .pid         (pid),
    .pid_valid   (pid_valid),
    .byte_count  (byte_count),
    .pkt_done    (pkt_done),
    .r_error     (r_error)
  );

  typedef struct {
    logic [7:0] sync_b;
    logic [7:0] pid_b;
    int         n_data;
    int         full_idx;
    bit         pend_eop;
    bit         eop_with_last;
    int         exp_writes;
    bit         exp_err;
    int         exp_done;
    bit         exp_pv;
    logic [3:0] exp_pid;
  } vec_t;

  vec_t       vecs[7];
  int         tests = 0;
  int         fails = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe must match the oldest expected payload byte.
  always @(negedge clk) begin
    if (n_rst) begin
      if (pkt_done) done_cnt++;
      if (w_enable) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("write_data", int'(rx_data), int'(mon_exp));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit full, input bit with_eop);
    rx_data   = b;
    byte_rcvd = 1'b1;
    fifo_full = full;
    if (with_eop) eop = 1'b1;
    tick();
    byte_rcvd = 1'b0;
    fifo_full = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_pkt(input string tag);
    wr_cnt   = 0;
    done_cnt = 0;
    exp_q.delete();
    start_edge = 1'b1;
    #3;
    check({tag, "_cnt_clear"}, int'(cnt_clear), 1);
    tick();
    start_edge = 1'b0;
    check({tag, "_rcving_start"}, int'(rcving), 1);
    check({tag, "_rerr_cleared"}, int'(r_error), 0);
    check({tag, "_pv_cleared"}, int'(pid_valid), 0);
    check({tag, "_count_cleared"}, int'(byte_count), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_pkt(tag);
    send_byte(v.sync_b, 1'b0, 1'b0);
    send_byte(v.pid_b, 1'b0, 1'b0);
    for (int i = 0; i < v.n_data; i++) begin
      if (i < v.exp_writes) exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), (i == v.full_idx), (v.eop_with_last && i == v.n_data - 1));
    end
    if (v.exp_err && !v.pend_eop) begin
      check({tag, "_err_before_eop"}, int'(r_error), 1);
      check({tag, "_rcving_in_err"}, int'(rcving), 1);
    end
    eop          = 1'b1;
    bits_pending = v.pend_eop;
    tick();
    tick();
    check({tag, "_rcving_during_eop"}, int'(rcving), int'(v.exp_err));
    eop          = 1'b0;
    bits_pending = 1'b0;
    tick();
    tick();
    check({tag, "_rcving_end"}, int'(rcving), 0);
    check({tag, "_r_error"}, int'(r_error), int'(v.exp_err));
    check({tag, "_pkt_done_cnt"}, done_cnt, v.exp_done);
    check({tag, "_writes"}, wr_cnt, v.exp_writes);
    check({tag, "_byte_count"}, int'(byte_count), v.exp_writes);
    check({tag, "_pid_valid"}, int'(pid_valid), int'(v.exp_pv));
    if (v.exp_pv) check({tag, "_pid"}, int'(pid), int'(v.exp_pid));
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //              sync    pid    n   full pend last wr  err done pv  pid
    vecs[0] = '{8'h80, 8'hC3, 3,  -1, 1'b0, 1'b0, 3,  1'b0, 1, 1'b1, 4'h3};
    vecs[1] = '{8'h81, 8'hC3, 3,  -1, 1'b0, 1'b0, 0,  1'b1, 0, 1'b0, 4'h0};
    vecs[2] = '{8'h80, 8'hD2, 2,  -1, 1'b1, 1'b0, 2,  1'b1, 0, 1'b1, 4'h2};
    vecs[3] = '{8'h80, 8'hE1, 3,  1,  1'b0, 1'b0, 1,  1'b1, 0, 1'b1, 4'h1};
    vecs[4] = '{8'h80, 8'hA5, 65, -1, 1'b0, 1'b0, 64, 1'b1, 0, 1'b1, 4'h5};
`ifdef RX_PID_CHECK_EN
    vecs[5] = '{8'h80, 8'hC4, 2,  -1, 1'b0, 1'b0, 0,  1'b1, 0, 1'b0, 4'h0};
`else
    vecs[5] = '{8'h80, 8'hC4, 2,  -1, 1'b0, 1'b0, 2,  1'b0, 1, 1'b1, 4'h4};
`endif
    vecs[6] = '{8'h80, 8'h96, 2,  -1, 1'b0, 1'b1, 2,  1'b0, 1, 1'b1, 4'h6};

    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("reset_rcving", int'(rcving), 0);
    check("reset_pid_valid", int'(pid_valid), 0);
    check("reset_pid", int'(pid), 0);
    check("reset_byte_count", int'(byte_count), 0);
    check("reset_r_error", int'(r_error), 0);
    check("reset_pkt_done", int'(pkt_done), 0);
    check("reset_cnt_clear", int'(cnt_clear), 0);
    check("reset_w_enable", int'(w_enable), 0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
      tick();
    end

    // Reset in the middle of a payload byte: everything drops at once and nothing is written.
    start_pkt("rst");
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    exp_q.push_back(8'h77);
    send_byte(8'h77, 1'b0, 1'b0);
    rx_data   = 8'h55;
    byte_rcvd = 1'b1;
    n_rst     = 1'b0;
    #1;
    check("rst_mid_rcving", int'(rcving), 0);
    check("rst_mid_w_enable", int'(w_enable), 0);
    check("rst_mid_pid", int'(pid), 0);
    check("rst_mid_pid_valid", int'(pid_valid), 0);
    check("rst_mid_byte_count", int'(byte_count), 0);
    check("rst_mid_r_error", int'(r_error), 0);
    check("rst_mid_pkt_done", int'(pkt_done), 0);
    check("rst_mid_writes", wr_cnt, 1);
    tick();
    byte_rcvd = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("rst_queue_empty", exp_q.size(), 0);
    check("rst_idle_rcving", int'(rcving), 0);

    // After reset a fresh packet must run normally.
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
